// File: rtl/bram_report_tx.sv
// bram_report_tx: paces BRAM test runs and reports each run's error count as an 8N1 UART frame.
// Optional feature macro REPORT_CHECKSUM_EN appends an XOR checksum byte to every frame.
module bram_report_tx #(
    parameter int BAUD_DIV  = 434,
    parameter int START_GAP = 50000
) (
    input  logic        REPORT_sys_clk,
    input  logic        REPORT_rst,
    input  logic        BRAM_end,
    input  logic [31:0] BRAM_error,
    output logic        BRAM_start,
    output logic        send_end,
    output logic        uart_tx,
    output logic        report_busy
);

    typedef enum logic [2:0] {
        GAP,
        REQ,
        LOAD,
        SEND,
        DONE
    } state_t;

`ifdef REPORT_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd4;
`endif
    localparam logic [23:0] GAP_LAST  = 24'(START_GAP - 1);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    state_t      state;
    logic [23:0] gap_cnt;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic [31:0] frame;
    logic        bram_end_q;
    logic [7:0]  cur_byte;
`ifdef REPORT_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    // Byte currently on the wire: sync header, error count MSB first, then the optional checksum.
    always_comb begin
        cur_byte = 8'hA5;
        case (byte_idx)
            3'd1:    cur_byte = frame[31:24];
            3'd2:    cur_byte = frame[23:16];
            3'd3:    cur_byte = frame[15:8];
            3'd4:    cur_byte = frame[7:0];
`ifdef REPORT_CHECKSUM_EN
            3'd5:    cur_byte = checksum;
`endif
            default: cur_byte = 8'hA5;
        endcase
    end

    always_ff @(posedge REPORT_sys_clk) begin
        if (REPORT_rst) begin
            state       <= GAP;
            gap_cnt     <= '0;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            frame       <= '0;
            bram_end_q  <= 1'b0;
            BRAM_start  <= 1'b0;
            send_end    <= 1'b0;
            uart_tx     <= 1'b1;
            report_busy <= 1'b0;
`ifdef REPORT_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            // Sampled every cycle so a level already high on entry to REQ never looks like an edge.
            bram_end_q <= BRAM_end;
            case (state)
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt     <= '0;
                        BRAM_start  <= 1'b1;
                        report_busy <= 1'b1;
                        state       <= REQ;
                    end else begin
                        gap_cnt <= gap_cnt + 24'd1;
                    end
                end
                REQ: begin
                    if (BRAM_end && !bram_end_q) begin
                        frame      <= BRAM_error;
                        BRAM_start <= 1'b0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
`ifdef REPORT_CHECKSUM_EN
                    checksum <= frame[31:24] ^ frame[23:16] ^ frame[15:8] ^ frame[7:0];
`endif
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    uart_tx  <= 1'b0;
                    state    <= SEND;
                end
                SEND: begin
                    // bit_idx 0 is the start bit, 1..8 the data bits, 9 the stop bit.
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            if (byte_idx == LAST_BYTE) begin
                                uart_tx  <= 1'b1;
                                send_end <= 1'b1;
                                state    <= DONE;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                                bit_idx  <= '0;
                                uart_tx  <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            uart_tx <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DONE: begin
                    send_end    <= 1'b0;
                    report_busy <= 1'b0;
                    gap_cnt     <= '0;
                    state       <= GAP;
                end
                default: state <= GAP;
            endcase
        end
    end

endmodule

// File: doc/bram_report_tx.md
BRAM_REPORT_TX -- requirements
Module: bram_report_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, meaning clock cycles per UART bit time (legal range 2..65535).
REQ-002 SHALL have parameter START_GAP, default 50000, meaning idle cycles between test runs (legal range 1..2^24-1).
REQ-003 SHALL have port REPORT_sys_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port REPORT_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port BRAM_end  input  1  test-done level from the BRAM test stage.
REQ-006 SHALL have port BRAM_error  input  32  error count from the BRAM test stage, valid while BRAM_end is high.
REQ-007 SHALL have port BRAM_start  output  1  run request to the BRAM test stage.
REQ-008 SHALL have port send_end  output  1  one-cycle pulse telling the BRAM test stage that the report is sent.
REQ-009 SHALL have port uart_tx  output  1  serial line, 8N1, idle high.
REQ-010 SHALL have port report_busy  output  1  high in every state except GAP.

Function
REQ-011 SHALL implement the states GAP, REQ, LOAD, SEND and DONE.
REQ-012 GAP: count START_GAP cycles, then go to REQ.
REQ-013 REQ: drive BRAM_start high and hold it until a BRAM_end rising edge is detected, then go to LOAD.
REQ-014 Edge detect: a rising edge is BRAM_end high in the current cycle and low in the previous registered sample; a level that is already high on entry to REQ SHALL NOT count.
REQ-015 BRAM_start SHALL drop in the cycle after the edge is detected.
REQ-016 LOAD: latch BRAM_error into a 32-bit frame register in the edge cycle, compute checksum = XOR of its four bytes, then go to SEND.
REQ-017 SEND, frame byte order: 0xA5, err[31:24], err[23:16], err[15:8], err[7:0], checksum (only when REPORT_CHECKSUM_EN is defined).
REQ-018 SEND, each byte: start bit 0, data LSB first, stop bit 1; each bit lasts exactly BAUD_DIV cycles; no idle gap between bytes.
REQ-019 Bit timing: the baud counter SHALL reload to 0 at each bit start and SHALL advance the bit index when the count reaches BAUD_DIV-1.
REQ-020 DONE: entered in the cycle after the final stop bit ends; assert send_end for exactly 1 cycle, then go to GAP with the gap counter reloaded.
REQ-021 BRAM_end changes after LOAD SHALL be ignored until the next REQ.
REQ-022 In DONE, BRAM_end still high SHALL NOT trigger a new run.
REQ-023 The frame register SHALL hold its value from LOAD through DONE even if BRAM_error changes.
REQ-024 An error count of 0xFFFFFFFF SHALL be sent unmodified; no saturation or wrap handling.

Reset
REQ-025 While REPORT_rst is high at a clock edge: state=GAP, gap counter=0, BRAM_start=0, send_end=0, uart_tx=1, report_busy=0, frame register=0, baud counter=0, bit index=0, byte index=0, BRAM_end sample=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; uart_tx SHALL be 1 from the next edge, and no send_end SHALL be issued for the aborted frame.
REQ-027 After reset releases, the first BRAM_start SHALL rise START_GAP cycles later.

Configuration
REQ-028 With macro REPORT_CHECKSUM_EN defined: the frame SHALL be 6 bytes (60 bit times) with the checksum last.
REQ-029 With REPORT_CHECKSUM_EN undefined: the frame SHALL be 5 bytes (50 bit times), and no checksum logic SHALL be synthesized.

Verification (BAUD_DIV=4, START_GAP=8)
REQ-030 Scenario: release reset, keep BRAM_end low -> BRAM_start rises at cycle 8 after release and stays high.
REQ-031 Scenario: during REQ, BRAM_error=0x00000000 and BRAM_end rises -> uart_tx sends bytes A5 00 00 00 00 00 with each bit 4 cycles; send_end pulses 1 cycle, 240 cycles after LOAD ends (checksum enabled).
REQ-032 Scenario: BRAM_error=0x12345678 -> bytes A5 12 34 56 78 08; change BRAM_error to 0 mid-frame -> the transmitted bytes are unchanged.
REQ-033 Scenario: BRAM_end already high on entry to REQ and high through DONE -> no frame starts until BRAM_end falls and rises again.
REQ-034 Scenario: assert reset during the third byte -> uart_tx=1 next cycle; send_end stays 0; BRAM_start reasserts 8 cycles after release.
REQ-035 Scenario: build without REPORT_CHECKSUM_EN, BRAM_error=0xFFFFFFFF -> bytes A5 FF FF FF FF only; send_end pulses 200 cycles after LOAD ends.
